// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and constants for the LC-3 memory sequencer
package lc3_mem_pkg;
   typedef enum logic [2:0] {IDLE, READ, WRITE, IORD, WDONE, DONE} mem_state_t;
   typedef enum logic [1:0] {OP_RD, OP_WR, OP_IORD, OP_IOWR} mem_op_t;
   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
endpackage

// File: rtl/tristate_dq.sv
// tristate_dq: registered SRAM data bus driver with a loadable read-capture register
module tristate_dq (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        oe_d,
   input  logic        wd_en,
   input  logic [15:0] wd,
   input  logic        cap_en,
   input  logic        cap_ext,
   input  logic [15:0] ext_data,
   output logic [15:0] rdata,
   inout  wire  [15:0] dq
);
   logic        oe_q;
   logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
   // next write data and captured read data
   always_comb begin
      wdata_d = wd_en ? wd : wdata_q;
      rdata_d = cap_en ? (cap_ext ? ext_data : dq) : rdata_q;
   end
   // bus enable, write data and capture registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         oe_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         oe_q    <= oe_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end
   assign dq    = oe_q ? wdata_q : 16'hzzzz;
   assign rdata = rdata_q;
endmodule

// File: rtl/lc3_mem_sequencer.sv
// lc3_mem_sequencer: turns LC-3 memory strobes into timed SRAM cycles and handles the MMIO word
module lc3_mem_sequencer
   import lc3_mem_pkg::*;
#(
   parameter int          RD_WAIT = 2,
   parameter int          WR_WAIT = 2,
   parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Mem_OE,
   input  logic        Mem_WE,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR_out,
   input  logic [15:0] Switches,
   output logic [15:0] Data_to_CPU,
   output logic        Mem_R,
   output logic        Busy,
   output logic        Err,
   output logic [15:0] Hex_reg,
   output logic [19:0] SRAM_ADDR,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   inout  wire  [15:0] SRAM_DQ
);
   mem_state_t  state_q, state_d;
   mem_op_t     op;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] mar_q, mar_d, hex_q, hex_d;
   logic        err_q, err_d, mem_r_q, mem_r_d;
   logic        sram_oe_n_q, sram_oe_n_d, sram_we_n_q, sram_we_n_d;
   logic        req, io, dq_oe_d, cap_en, cap_ext;
   assign req = !Mem_WE || !Mem_OE;
   assign io  = MAR == IO_ADDR;
   assign op  = !Mem_WE ? (io ? OP_IOWR : OP_WR) : (io ? OP_IORD : OP_RD);
   // state, counter and all registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mar_q       <= '0;
         hex_q       <= '0;
         err_q       <= 1'b0;
         mem_r_q     <= 1'b0;
         sram_oe_n_q <= 1'b1;
         sram_we_n_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mar_q       <= mar_d;
         hex_q       <= hex_d;
         err_q       <= err_d;
         mem_r_q     <= mem_r_d;
         sram_oe_n_q <= sram_oe_n_d;
         sram_we_n_q <= sram_we_n_d;
      end
   end
   // next state and wait counter; write wins when both strobes are low
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (req) begin
            state_d = op == OP_WR ? WRITE : op == OP_IOWR ? DONE : op == OP_IORD ? IORD : READ;
            cnt_d   = op == OP_WR ? 4'(WR_WAIT - 1) : 4'(RD_WAIT - 1);
         end
         READ: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd0 ? DONE : READ;
         end
         WRITE: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd0 ? WDONE : WRITE;
         end
         IORD, WDONE: state_d = DONE;
         DONE: state_d = (Mem_OE && Mem_WE) ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // strobes, ready pulse, latches and read-capture controls derived from the transition
   always_comb begin
      sram_oe_n_d = state_d != READ;
      sram_we_n_d = state_d != WRITE;
      dq_oe_d     = state_d == WRITE || state_d == WDONE;
      mem_r_d     = state_d == DONE && state_q != DONE;
      err_d       = err_q | (!Mem_OE & !Mem_WE);
      mar_d       = state_q == IDLE ? MAR : mar_q;
      hex_d       = (state_q == IDLE && req && op == OP_IOWR) ? MDR_out : hex_q;
      cap_en      = (state_q == READ && cnt_q == 4'd0) || state_q == IORD;
      cap_ext     = state_q == IORD;
   end
   tristate_dq u_dq (
      .Clk     (Clk),
      .Reset   (Reset),
      .oe_d    (dq_oe_d),
      .wd_en   (state_q == IDLE),
      .wd      (MDR_out),
      .cap_en  (cap_en),
      .cap_ext (cap_ext),
      .ext_data(Switches),
      .rdata   (Data_to_CPU),
      .dq      (SRAM_DQ)
   );
   assign Mem_R     = mem_r_q;
   assign Busy      = state_q != IDLE;
   assign Err       = err_q;
   assign Hex_reg   = hex_q;
   assign SRAM_ADDR = {4'b0, mar_q};
   assign SRAM_CE_N = state_q == IDLE;
   assign SRAM_UB_N = state_q == IDLE;
   assign SRAM_LB_N = state_q == IDLE;
   assign SRAM_OE_N = sram_oe_n_q;
   assign SRAM_WE_N = sram_we_n_q;
endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// tb_lc3_mem_sequencer: scoreboard bench with an async SRAM model for lc3_mem_sequencer
module tb_lc3_mem_sequencer;
   logic        Clk = 1'b0;
   logic        Reset, Mem_OE, Mem_WE;
   logic [15:0] MAR, MDR_out, Switches;
   logic [15:0] Data_to_CPU, Hex_reg;
   logic        Mem_R, Busy, Err;
   logic [19:0] SRAM_ADDR;
   logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;
   wire  [15:0] SRAM_DQ;
   logic [15:0] sram [0:65535];
   logic [15:0] exp_data_q [$];
   int          exp_cyc_q [$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          mem_r_cnt = 0;

   lc3_mem_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .MAR(MAR),
      .MDR_out(MDR_out), .Switches(Switches), .Data_to_CPU(Data_to_CPU), .Mem_R(Mem_R),
      .Busy(Busy), .Err(Err), .Hex_reg(Hex_reg), .SRAM_ADDR(SRAM_ADDR),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
      .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ(SRAM_DQ)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR[15:0]] : 16'hzzzz;
   always @(posedge Clk) if (!SRAM_CE_N && !SRAM_WE_N) sram[SRAM_ADDR[15:0]] <= SRAM_DQ;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge Clk) begin
      if (!SRAM_OE_N && !SRAM_WE_N) check("strobe_overlap", 1, 0);
      if (Mem_R === 1'b1) begin
         mem_r_cnt++;
         if (exp_data_q.size() == 0) check("spurious_mem_r", 1, 0);
         else begin
            check("mem_r_data", Data_to_CPU, exp_data_q.pop_front());
            check("mem_r_cycle", cyc, exp_cyc_q.pop_front());
         end
      end
   end

   task automatic access(input logic wr, input logic rd, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_data,
                         input int lat, input int exp_oe, input int exp_we, input int hold);
      int oe_n, we_n, dqd, r0;
      logic got;
      oe_n = 0; we_n = 0; dqd = 0; got = 1'b0; r0 = mem_r_cnt;
      Mem_OE = !rd; Mem_WE = !wr; MAR = addr; MDR_out = wdata;
      exp_data_q.push_back(exp_data);
      exp_cyc_q.push_back(cyc + lat);
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge Clk);
         if (!SRAM_OE_N) oe_n++;
         if (!SRAM_WE_N) we_n++;
         if (dut.u_dq.oe_q) begin
            dqd++;
            if (SRAM_DQ !== wdata) check("dq_data", SRAM_DQ, wdata);
         end
         got = Mem_R;
      end
      if (!got) check("mem_r_timeout", 0, 1);
      check("oe_cycles", oe_n, exp_oe);
      check("we_cycles", we_n, exp_we);
      check("dq_cycles", dqd, exp_we > 0 ? exp_we + 1 : 0);
      repeat (hold) @(negedge Clk);
      if (hold > 0) begin
         check("held_busy", Busy, 1);
         check("held_one_mem_r", mem_r_cnt - r0, 1);
      end
      Mem_OE = 1'b1; Mem_WE = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (!Busy) break;
      end
      check("back_idle", Busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; MAR = '0; MDR_out = '0; Switches = 16'h00A5;
      sram[16'h3000] = 16'hBEEF;
      repeat (3) @(negedge Clk);
      check("rst_oe_n", SRAM_OE_N, 1);
      check("rst_we_n", SRAM_WE_N, 1);
      check("rst_ce_n", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 3'b111);
      check("rst_dq_oe", dut.u_dq.oe_q, 0);
      check("rst_data", Data_to_CPU, 0);
      check("rst_hex", Hex_reg, 0);
      check("rst_flags", {Mem_R, Busy, Err}, 3'b000);
      Reset = 1'b0;
      @(negedge Clk);
      access(1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, 3, 2, 0, 0);
      access(1'b1, 1'b0, 16'h0010, 16'h1234, 16'hBEEF, 4, 0, 2, 0);
      access(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 3, 2, 0, 0);
      access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h00A5, 2, 0, 0, 0);
      access(1'b1, 1'b0, 16'hFFFF, 16'h7777, 16'h00A5, 1, 0, 0, 0);
      check("hex_write", Hex_reg, 16'h7777);
      check("no_err_yet", Err, 0);
      access(1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, 3, 2, 0, 7);
      access(1'b1, 1'b1, 16'h0020, 16'h5A5A, 16'hBEEF, 4, 0, 2, 0);
      check("conflict_err", Err, 1);
      access(1'b0, 1'b1, 16'h0020, 16'h0000, 16'h5A5A, 3, 2, 0, 0);
      check("err_sticky", Err, 1);
      Mem_WE = 1'b0; MAR = 16'h0030; MDR_out = 16'h9999;
      repeat (2) @(negedge Clk);
      check("pre_rst_busy", Busy, 1);
      check("pre_rst_we_n", SRAM_WE_N, 0);
      Reset = 1'b1; Mem_WE = 1'b1;
      @(negedge Clk);
      check("midrst_strobes", {SRAM_OE_N, SRAM_WE_N, SRAM_CE_N}, 3'b111);
      check("midrst_dq_oe", dut.u_dq.oe_q, 0);
      check("midrst_flags", {Mem_R, Busy, Err}, 3'b000);
      check("midrst_hex", Hex_reg, 0);
      check("midrst_data", Data_to_CPU, 0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      access(1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, 3, 2, 0, 0);
      check("err_cleared", Err, 0);
      check("sb_empty", exp_data_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
